// File: rtl/mem_bus_arbiter.sv
// Shares one mem_bus target between NUM_REQ controllers: port 0 has priority capped by PRIO_LIMIT, the rest round-robin.
// Grant reaches the memory side 1 clk after request; one transaction in flight; requesters hold request until req_ack.
module mem_bus_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int PRIO_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_request,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_address,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  input  logic [2*NUM_REQ-1:0]    req_wmask,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [15:0]             req_rdata,
  output logic                    mem_request,
  output logic                    mem_write,
  output logic [31:0]             mem_address,
  output logic [15:0]             mem_wdata,
  output logic [1:0]              mem_wmask,
  input  logic                    mem_ack,
  input  logic [15:0]             mem_rdata,
  output logic [2:0]              grant_id,
  output logic                    busy
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } cmd_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gid_q, gid_d, rr_q, rr_d;
  logic [IW-1:0] win, rr_win, win_hi, win_lo;
  logic [3:0]    prio_q, prio_d;
  logic          withdrawn_q, live_req, others_pending, p0_wins, found_hi;
  cmd_t          live_cmd, hold_cmd, out_cmd;

  always_comb begin
    live_req = 1'b0;
    live_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IW'(i)) begin
        live_req         = req_request[i];
        live_cmd.write   = req_write[i];
        live_cmd.address = req_address[32*i +: 32];
        live_cmd.wdata   = req_wdata[16*i +: 16];
        live_cmd.wmask   = req_wmask[2*i +: 2];
      end
    end
  end

  // Once the granted port withdraws, memory keeps seeing the command it was given.
  assign out_cmd = withdrawn_q ? hold_cmd : live_cmd;

  // Descending scan leaves the lowest requesting port at/after rr_q in win_hi, lowest overall in win_lo.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req_request[i]) begin
        win_lo = IW'(i);
        if (IW'(i) >= rr_q) begin
          found_hi = 1'b1;
          win_hi   = IW'(i);
        end
      end
    end
  end

  assign rr_win         = found_hi ? win_hi : win_lo;
  assign others_pending = |req_request[NUM_REQ-1:1];
  assign p0_wins        = req_request[0] && !(others_pending && prio_q == 4'(PRIO_LIMIT));
  assign win            = p0_wins ? '0 : rr_win;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    prio_d  = prio_q;
    req_ack = '0;
    case (state_q)
      IDLE: begin
        if (|req_request) begin
          state_d = BUSY;
          gid_d   = win;
          if (p0_wins) begin
            prio_d = others_pending ? ((prio_q == 4'hF) ? prio_q : prio_q + 4'd1) : 4'd0;
          end else begin
            prio_d = 4'd0;
            rr_d   = (win == IW'(NUM_REQ - 1)) ? IW'(1) : win + IW'(1);
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = (gid_q == IW'(i)) && live_req && !withdrawn_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      rr_q        <= IW'(1);
      prio_q      <= '0;
      withdrawn_q <= 1'b0;
      hold_cmd    <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      prio_q  <= prio_d;
      if (state_q == IDLE) begin
        withdrawn_q <= 1'b0;
      end else if (!withdrawn_q && !live_req) begin
        withdrawn_q <= 1'b1;
        hold_cmd    <= live_cmd;
      end
    end
  end

  assign mem_request = (state_q == BUSY);
  assign busy        = (state_q == BUSY);
  assign mem_write   = out_cmd.write;
  assign mem_address = out_cmd.address;
  assign mem_wdata   = out_cmd.wdata;
  assign mem_wmask   = out_cmd.wmask;
  assign req_rdata   = mem_rdata;
  assign grant_id    = 3'(gid_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a rule-level grant model.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_mem_bus_arbiter;
  localparam int N   = 3;
  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_request, req_write, req_ack;
  logic [32*N-1:0] req_address;
  logic [16*N-1:0] req_wdata;
  logic [2*N-1:0]  req_wmask;
  logic [15:0]     req_rdata, mem_wdata, mem_rdata;
  logic            mem_request, mem_write, mem_ack, busy;
  logic [31:0]     mem_address;
  logic [1:0]      mem_wmask;
  logic [2:0]      grant_id;

  int total = 0;
  int bad   = 0;

  // memory model controls
  bit          mem_auto = 0, lat_rand = 0, rd_rand = 0, force_ack = 0;
  int          mem_lat = 0, mem_cnt = 0;
  logic [15:0] rd_val = 16'hBEEF;

  // reference model state
  bit           m_busy;
  int           m_gid, m_prio, m_rr, grants;
  int           gap[N];
  logic [N-1:0] last_ack;

  mem_bus_arbiter #(.NUM_REQ(N), .PRIO_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .req_request(req_request), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ack(req_ack), .req_rdata(req_rdata),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_val;
      force_ack = 0;
    end else if (mem_auto && mem_request) begin
      if (mem_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
        if (rd_rand) rd_val = 16'($urandom);
        if (lat_rand) mem_lat = $urandom_range(0, 3);
        mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req_request = '0;
    mem_auto = 0; force_ack = 0; mem_cnt = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    req_request = 3'b111;
    tick();
    @(negedge clk);
    total++; if (mem_request !== 1'b0) begin bad++; $display("FAIL reset_mem_request: got %b want 0", mem_request); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL reset_req_ack: got %b want 000", req_ack); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    req_request = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int waited;
    do_reset();
    mem_auto = 1; mem_lat = 2; lat_rand = 0; rd_rand = 0; rd_val = 16'hBEEF;
    req_address[63:32] = 32'h0000_1000;
    req_write[1] = 1'b0;
    req_request = 3'b010;
    @(negedge clk);
    total++; if (mem_request !== 1'b0) begin bad++; $display("FAIL read_req_latency: got %b want 0", mem_request); end
    tick();
    @(negedge clk);
    total++; if (mem_request !== 1'b1) begin bad++; $display("FAIL read_mem_request: got %b want 1", mem_request); end
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL read_grant_id: got %0d want 1", grant_id); end
    total++; if (mem_address !== 32'h0000_1000 || mem_write !== 1'b0) begin bad++; $display("FAIL read_cmd: got addr=%h wr=%b want 00001000 0", mem_address, mem_write); end
    waited = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      waited++;
      if (req_ack !== 3'b000) break;
    end
    total++; if (waited !== 2) begin bad++; $display("FAIL read_ack_time: got %0d want 2", waited); end
    total++; if (req_ack !== 3'b010) begin bad++; $display("FAIL read_req_ack: got %b want 010", req_ack); end
    total++; if (req_rdata !== 16'hBEEF) begin bad++; $display("FAIL read_rdata: got %h want beef", req_rdata); end
    tick();
    req_request = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || mem_request !== 1'b0) begin bad++; $display("FAIL read_busy_after: got busy=%b req=%b want 0 0", busy, mem_request); end
  endtask

  task automatic test_priority();
    int exp_seq[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0};
    int n = 0;
    do_reset();
    mem_auto = 1; mem_lat = 0; lat_rand = 0;
    req_request = 3'b111;
    for (int c = 0; c < 80 && n < 12; c++) begin
      tick();
      @(negedge clk);
      if (req_ack !== 3'b000) begin
        total++;
        if (grant_id !== 3'(exp_seq[n]) || req_ack !== 3'(1 << exp_seq[n])) begin
          bad++; $display("FAIL prio_grant[%0d]: got id=%0d ack=%b want id=%0d", n, grant_id, req_ack, exp_seq[n]);
        end
        n++;
      end
    end
    total++; if (n != 12) begin bad++; $display("FAIL prio_count: got %0d grants want 12", n); end
    tick();
    req_request = '0;
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{1, 2, 1, 2, 1, 2};
    int n = 0;
    do_reset();
    mem_auto = 1; mem_lat = 1; lat_rand = 0;
    req_request = 3'b110;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      @(negedge clk);
      if (req_ack !== 3'b000) begin
        total++;
        if (grant_id !== 3'(exp_seq[n]) || req_ack !== 3'(1 << exp_seq[n])) begin
          bad++; $display("FAIL rr_grant[%0d]: got id=%0d ack=%b want id=%0d", n, grant_id, req_ack, exp_seq[n]);
        end
        n++;
      end
    end
    total++; if (n != 6) begin bad++; $display("FAIL rr_count: got %0d grants want 6", n); end
    tick();
    req_request = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_address[31:0] = 32'h03FE_0010;
    req_wdata[15:0]   = 16'h1234;
    req_wmask[1:0]    = 2'b11;
    req_write[0]      = 1'b1;
    req_request       = 3'b001;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++; if (grant_id !== 3'd0 || mem_request !== 1'b1) begin bad++; $display("FAIL wd_grant: got id=%0d req=%b want 0 1", grant_id, mem_request); end
    tick();
    req_request[0] = 1'b0;
    @(negedge clk);
    tick();
    req_address[31:0] = 32'hDEAD_0000;
    req_wdata[15:0]   = 16'h0000;
    req_wmask[1:0]    = 2'b00;
    req_write[0]      = 1'b0;
    @(negedge clk);
    total++; if (mem_request !== 1'b1) begin bad++; $display("FAIL wd_mem_request: got %b want 1", mem_request); end
    total++; if (mem_address !== 32'h03FE_0010 || mem_wdata !== 16'h1234) begin bad++; $display("FAIL wd_frozen: got addr=%h wdata=%h want 03fe0010 1234", mem_address, mem_wdata); end
    total++; if (mem_wmask !== 2'b11 || mem_write !== 1'b1) begin bad++; $display("FAIL wd_frozen_ctl: got mask=%b wr=%b want 11 1", mem_wmask, mem_write); end
    force_ack = 1; rd_val = 16'h5555;
    tick();
    @(negedge clk);
    total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL wd_no_ack: got %b want 000", req_ack); end
    tick();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_idle: got busy=%b want 0", busy); end
    req_address[63:32] = 32'h0000_2000;
    req_request = 3'b010;
    tick();
    @(negedge clk);
    total++; if (grant_id !== 3'd1 || mem_address !== 32'h0000_2000) begin bad++; $display("FAIL wd_next_grant: got id=%0d addr=%h want 1 00002000", grant_id, mem_address); end
    force_ack = 1;
    tick();
    @(negedge clk);
    total++; if (req_ack !== 3'b010) begin bad++; $display("FAIL wd_next_ack: got %b want 010", req_ack); end
    tick();
    req_request = '0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_address[63:32] = 32'h0000_3000;
    req_request = 3'b010;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++; if (mem_request !== 1'b1) begin bad++; $display("FAIL rb_busy: got %b want 1", mem_request); end
    tick();
    reset = 1'b1;
    req_request = '0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (mem_request !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rb_state: got req=%b busy=%b want 0 0", mem_request, busy); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rb_grant_id: got %0d want 0", grant_id); end
    force_ack = 1;
    tick();
    @(negedge clk);
    total++; if (req_ack !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL rb_stray_ack: got ack=%b busy=%b want 000 0", req_ack, busy); end
    tick();
    req_request = 3'b100;
    @(negedge clk);
    total++; if (mem_request !== 1'b0) begin bad++; $display("FAIL rb_latency0: got %b want 0", mem_request); end
    tick();
    @(negedge clk);
    total++; if (mem_request !== 1'b1 || grant_id !== 3'd2) begin bad++; $display("FAIL rb_regrant: got req=%b id=%0d want 1 2", mem_request, grant_id); end
    force_ack = 1;
    tick();
    @(negedge clk);
    total++; if (req_ack !== 3'b100) begin bad++; $display("FAIL rb_ack: got %b want 100", req_ack); end
    tick();
    req_request = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_request = 3'b010;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL sc_grant1: got %0d want 1", grant_id); end
    force_ack = 1;
    tick();
    req_address[95:64] = 32'h0000_4000;
    req_request[2] = 1'b1;
    @(negedge clk);
    total++; if (req_ack !== 3'b010) begin bad++; $display("FAIL sc_ack1: got %b want 010", req_ack); end
    tick();
    req_request[1] = 1'b0;
    @(negedge clk);
    total++; if (mem_request !== 1'b0) begin bad++; $display("FAIL sc_idle_gap: got %b want 0", mem_request); end
    tick();
    @(negedge clk);
    total++; if (mem_request !== 1'b1 || grant_id !== 3'd2 || mem_address !== 32'h0000_4000) begin
      bad++; $display("FAIL sc_grant2: got req=%b id=%0d addr=%h want 1 2 00004000", mem_request, grant_id, mem_address);
    end
    force_ack = 1;
    tick();
    @(negedge clk);
    total++; if (req_ack !== 3'b100) begin bad++; $display("FAIL sc_ack2: got %b want 100", req_ack); end
    tick();
    req_request = '0;
  endtask

  // Winner from the arbitration rules, applied to the sampled request vector.
  function automatic int model_pick(input logic [N-1:0] r);
    bit others = |r[N-1:1];
    if (r[0] && !(others && m_prio == LIM)) return 0;
    for (int s = 0; s < N - 1; s++) begin
      int k = (m_rr - 1 + s) % (N - 1) + 1;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic random_cycle(input bit allow_new);
    int w;
    bit others;
    tick();
    for (int p = 0; p < N; p++) begin
      if (req_request[p] && last_ack[p]) begin
        req_request[p] = 1'b0;
        gap[p] = $urandom_range(0, 3);
      end else if (!req_request[p]) begin
        if (gap[p] > 0) gap[p]--;
        else if (allow_new && $urandom_range(0, 1) == 1) begin
          req_address[p*32 +: 32] = $urandom;
          req_wdata[p*16 +: 16]   = 16'($urandom);
          req_wmask[p*2 +: 2]     = 2'($urandom);
          req_write[p]            = 1'($urandom);
          req_request[p]          = 1'b1;
        end
      end
    end
    @(negedge clk);
    total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy: got %b want %b", busy, m_busy); end
    if (!m_busy) begin
      total++; if (mem_request !== 1'b0 || req_ack !== 3'b000) begin bad++; $display("FAIL rnd_idle: got req=%b ack=%b want 0 000", mem_request, req_ack); end
      if (|req_request) begin
        others = |req_request[N-1:1];
        w = model_pick(req_request);
        if (w == 0) m_prio = others ? m_prio + 1 : 0;
        else begin
          m_prio = 0;
          m_rr = w % (N - 1) + 1;
        end
        m_gid = w;
        m_busy = 1;
      end
    end else begin
      total++; if (mem_request !== 1'b1 || grant_id !== 3'(m_gid)) begin bad++; $display("FAIL rnd_grant: got req=%b id=%0d want 1 %0d", mem_request, grant_id, m_gid); end
      total++; if (mem_address !== req_address[m_gid*32 +: 32] || mem_wdata !== req_wdata[m_gid*16 +: 16]) begin
        bad++; $display("FAIL rnd_mux: got addr=%h wdata=%h want %h %h", mem_address, mem_wdata, req_address[m_gid*32 +: 32], req_wdata[m_gid*16 +: 16]);
      end
      if (mem_ack) begin
        total++; if (req_ack !== 3'(1 << m_gid) || req_rdata !== mem_rdata) begin
          bad++; $display("FAIL rnd_ack: got ack=%b rdata=%h want %b %h", req_ack, req_rdata, 3'(1 << m_gid), mem_rdata);
        end
        grants++;
        m_busy = 0;
      end else begin
        total++; if (req_ack !== 3'b000) begin bad++; $display("FAIL rnd_no_ack: got %b want 000", req_ack); end
      end
    end
    last_ack = req_ack;
  endtask

  task automatic test_random();
    do_reset();
    m_busy = 0; m_gid = 0; m_prio = 0; m_rr = 1; grants = 0; last_ack = '0;
    for (int p = 0; p < N; p++) gap[p] = 0;
    mem_auto = 1; lat_rand = 1; rd_rand = 1; mem_lat = 1;
    @(negedge clk);
    for (int c = 0; c < 600; c++) random_cycle(1'b1);
    for (int c = 0; c < 60; c++) random_cycle(1'b0);
    total++; if (busy !== 1'b0 || req_request !== 3'b000) begin bad++; $display("FAIL rnd_drain: got busy=%b req=%b want 0 000", busy, req_request); end
    total++; if (grants < 40) begin bad++; $display("FAIL rnd_progress: got %0d grants want at least 40", grants); end
  endtask

  initial begin
    reset = 1'b1;
    req_request = '0; req_write = '0; req_address = '0; req_wdata = '0; req_wmask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_withdraw();
    test_reset_busy();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single SDRAM/flash mem_bus target between several mem_bus controllers: N64 PI (port 0), USB/DMA engine, CPU bridge.
- Port 0 has fixed priority, bounded by a starvation limit. Remaining ports are served round-robin.
- One transaction is outstanding at a time. The winner's request/address/data are multiplexed to the memory side, and ack/rdata are routed back.
- Sits between the requesting controllers and the memory controller, inside the clk domain.

Parameters:
- NUM_REQ, 3, number of requester ports (2..8); port 0 is the priority port.
- PRIO_LIMIT, 4, maximum consecutive port-0 grants while any other port is pending (1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_request  input  NUM_REQ  per-port request; held high until that port's ack
- req_write  input  NUM_REQ  per-port 1=write, 0=read
- req_address  input  32*NUM_REQ  per-port byte address, port i at [32i+31:32i]
- req_wdata  input  16*NUM_REQ  per-port write data
- req_wmask  input  2*NUM_REQ  per-port byte mask
- req_ack  output  NUM_REQ  one-cycle completion pulse to the granted port
- req_rdata  output  16  read data, broadcast; valid in the req_ack cycle
- mem_request  output  1  request to memory controller
- mem_write, mem_address[31:0], mem_wdata[15:0], mem_wmask[1:0]  output  various  muxed from the granted port
- mem_ack  input  1  one-cycle completion from memory
- mem_rdata  input  16  memory read data, valid with mem_ack
- grant_id  output  3  index of the current/last granted port (debug)
- busy  output  1  transaction outstanding

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_request=0, req_ack=0, busy=0.
  - grant_id=0, rr_ptr=1, prio_cnt=0.
- Reset mid-transaction: abandon immediately, go to IDLE, no ack issued. Any late mem_ack is ignored.
- IDLE:
  - If any req_request is set, register the winner into grant_id, set mem_request=1, busy=1, go to BUSY.
  - Grant is visible on the mem side the cycle after request is sampled; latency is 1 clk.
- Winner selection:
  - others_pending = any req_request[1..NUM_REQ-1].
  - Port 0 wins if requesting, unless others_pending && prio_cnt==PRIO_LIMIT.
  - Otherwise the first requesting port in [1..NUM_REQ-1] starting at rr_ptr wins, wrapping NUM_REQ-1→1.
- prio_cnt update at grant:
  - Port 0 granted with others_pending: saturating +1.
  - Port 0 granted, no others pending: 0.
  - Other port granted: 0.
- rr_ptr update at grant: on a grant to port k≥1, rr_ptr=k+1, wrapping to 1. It is unchanged on port-0 grants.
- BUSY:
  - mem_write/address/wdata/wmask are combinationally muxed from the grant_id port.
  - On mem_ack: req_ack[grant_id]=1 in the same cycle (combinational), req_rdata=mem_rdata, mem_request=0, busy=0, go to IDLE.
- Minimum gap: IDLE spends at least one cycle after every ack, because the requester drops its request in the cycle after ack. The arbiter never samples a stale request, giving at most one grant per 2 clks + memory latency.
- Withdrawn request: if req_request[grant_id] falls while BUSY before mem_ack (e.g. PI bus reset):
  - mem_request stays 1; memory cannot abort.
  - Muxed signals are frozen to their values from the withdrawal cycle.
  - On mem_ack: no req_ack is pulsed; return to IDLE normally.
- Simultaneous events:
  - A request arriving in the mem_ack cycle is considered in the next IDLE cycle.
  - Multiple requesters in the same cycle are resolved only by the selection rule above.
- req_ack bits other than grant_id are always 0. At most one req_ack bit is high per cycle.
- mem_ack while IDLE (spurious) is ignored.

Test Plan:
- Single port-1 read of 0x0000_1000, memory acks after 3 clks with 0xBEEF → mem_request rises 1 clk after request; req_ack[1] pulses with req_rdata=0xBEEF; busy low next cycle.
- Ports 0,1,2 request continuously, PRIO_LIMIT=4 → grant sequence 0,0,0,0,1,0,0,0,0,2,0,…; prio_cnt returns to 0 after each non-zero grant.
- Ports 1 and 2 only, continuous → grants alternate 1,2,1,2; rr_ptr wraps correctly with NUM_REQ=3.
- Port 0 write (address 0x03FE_0010, wdata 0x1234, wmask 2'b11) granted, then req_request[0] dropped before mem_ack → mem_request held until ack; mem_address/wdata unchanged; no req_ack pulsed; next grant proceeds normally.
- Reset asserted while BUSY, mem_ack arrives one clk after reset release → all outputs at reset values; stray ack produces no req_ack; next request granted with 1-clk latency.
- Port 2 request asserted in the same cycle as mem_ack for port 1 → port 2 granted after exactly one IDLE cycle.
